adder_cla_pipe: RTL and testbench



---
 rtl/adder_cla_pipe.sv | 175 +++++++++++++++++
 tb/tb_adder_cla_pipe.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/adder_cla_pipe.sv
// Pipelined carry-lookahead adder/subtractor. The operand is split into STAGES
// segments of 4-bit CLA groups, and the carry is registered between segments.
module adder_cla_pipe #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [0:WIDTH-1] a,
    input  logic [0:WIDTH-1] b,
    input  logic             c_in,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [0:WIDTH-1] s,
    output logic             c_out,
    output logic             ovf,
    output logic             zero
);

    localparam int SEG  = WIDTH / STAGES;
    localparam int NGRP = SEG / 4;
    localparam int LAST = STAGES - 1;

    typedef struct packed {
        logic             cout;
        logic             cmsb;
        logic [SEG-1:0]   sum;
    } seg_res_t;

    // Both group and bit carries are built as flat sum-of-products terms, so
    // there is no carry chain across groups inside a segment.
    function automatic seg_res_t cla_seg(input logic [SEG-1:0] x,
                                         input logic [SEG-1:0] y,
                                         input logic           ci);
        seg_res_t        r;
        logic [SEG-1:0]  g;
        logic [SEG-1:0]  p;
        logic [SEG-1:0]  c;
        logic [NGRP-1:0] gg;
        logic [NGRP-1:0] gp;
        logic [NGRP:0]   gc;
        logic            pp;
        int              base;
        g = x & y;
        p = x ^ y;
        for (int j = 0; j < NGRP; j++) begin
            gg[j] = 1'b0;
            pp    = 1'b1;
            for (int u = 3; u >= 0; u--) begin
                gg[j] = gg[j] | (pp & g[4*j+u]);
                pp    = pp & p[4*j+u];
            end
            gp[j] = pp;
        end
        gc    = '0;
        gc[0] = ci;
        for (int j = 1; j <= NGRP; j++) begin
            pp = 1'b1;
            for (int i = j - 1; i >= 0; i--) begin
                gc[j] = gc[j] | (pp & gg[i]);
                pp    = pp & gp[i];
            end
            gc[j] = gc[j] | (pp & ci);
        end
        for (int i = 0; i < SEG; i++) begin
            base = (i / 4) * 4;
            c[i] = 1'b0;
            pp   = 1'b1;
            for (int u = i - 1; u >= base; u--) begin
                c[i] = c[i] | (pp & g[u]);
                pp   = pp & p[u];
            end
            c[i] = c[i] | (pp & gc[i/4]);
        end
        r.sum  = p ^ c;
        r.cmsb = c[SEG-1];
        r.cout = gc[NGRP];
        return r;
    endfunction

    logic [WIDTH-1:0] a_n;
    logic [WIDTH-1:0] b_n;

    logic             stg_v [STAGES];
    logic             stg_c [STAGES];
    logic [WIDTH-1:0] stg_a [STAGES];
    logic [WIDTH-1:0] stg_b [STAGES];
    logic [WIDTH-1:0] stg_s [STAGES];

    seg_res_t         seg_r [STAGES];
    logic [WIDTH-1:0] nxt_a [STAGES];
    logic [WIDTH-1:0] nxt_b [STAGES];
    logic [WIDTH-1:0] nxt_s [STAGES];

    logic             v_q [STAGES];
    logic             c_q [STAGES];
    logic [WIDTH-1:0] a_q [STAGES];
    logic [WIDTH-1:0] b_q [STAGES];
    logic [WIDTH-1:0] s_q [STAGES];
    logic             ovf_q;
    logic             zero_q;

    assign a_n = a;
    assign b_n = b ^ {WIDTH{sub}};

    // Operands shift down one segment per stage so the active segment is always
    // at the bottom; sum segments enter at the top and reach their place at the end.
    always_comb begin
        stg_v[0] = in_valid;
        stg_c[0] = c_in;
        stg_a[0] = a_n;
        stg_b[0] = b_n;
        stg_s[0] = '0;
        for (int k = 1; k < STAGES; k++) begin
            stg_v[k] = v_q[k-1];
            stg_c[k] = c_q[k-1];
            stg_a[k] = a_q[k-1];
            stg_b[k] = b_q[k-1];
            stg_s[k] = s_q[k-1];
        end
    end

    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            seg_r[k] = cla_seg(stg_a[k][SEG-1:0], stg_b[k][SEG-1:0], stg_c[k]);
            nxt_a[k] = stg_a[k] >> SEG;
            nxt_b[k] = stg_b[k] >> SEG;
            nxt_s[k] = (stg_s[k] >> SEG) | (WIDTH'(seg_r[k].sum) << (WIDTH - SEG));
        end
    end

    assign in_ready = ~v_q[LAST] | out_ready;

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int k = 0; k < STAGES; k++) begin
                v_q[k] <= 1'b0;
                c_q[k] <= 1'b0;
                a_q[k] <= '0;
                b_q[k] <= '0;
                s_q[k] <= '0;
            end
            ovf_q  <= 1'b0;
            zero_q <= 1'b0;
        end else if (in_ready) begin
            for (int k = 0; k < STAGES; k++) begin
                v_q[k] <= stg_v[k];
                if (stg_v[k]) begin
                    c_q[k] <= seg_r[k].cout;
                    a_q[k] <= nxt_a[k];
                    b_q[k] <= nxt_b[k];
                    s_q[k] <= nxt_s[k];
                end
            end
            if (stg_v[LAST]) begin
                ovf_q  <= seg_r[LAST].cout ^ seg_r[LAST].cmsb;
                zero_q <= ~|nxt_s[LAST];
            end
        end
    end

    // The last stage has no further segments to feed its operand registers into.
    logic unused_tail;
    assign unused_tail = ^{a_q[LAST], b_q[LAST]};

    assign out_valid = v_q[LAST];
    assign s         = s_q[LAST];
    assign c_out     = c_q[LAST];
    assign ovf       = ovf_q;
    assign zero      = zero_q;

endmodule

// File: tb/tb_adder_cla_pipe.sv
// Bench for adder_cla_pipe: a 24-bit/3-stage and a 32-bit/2-stage instance,
// directed vector table, handshake sequences and a randomized scoreboard.
module tb_adder_cla_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic        iv24, ir24, ov24, or24, ci24, sb24, co24, of24, z24;
    logic [0:23] a24, b24, s24;
    logic        iv32, ir32, ov32, or32, ci32, sb32, co32, of32, z32;
    logic [0:31] a32, b32, s32;

    adder_cla_pipe #(.WIDTH(24), .STAGES(3)) dut24 (
        .clk(clk), .rst(rst), .in_valid(iv24), .in_ready(ir24), .a(a24), .b(b24),
        .c_in(ci24), .sub(sb24), .out_valid(ov24), .out_ready(or24), .s(s24),
        .c_out(co24), .ovf(of24), .zero(z24));

    adder_cla_pipe #(.WIDTH(32), .STAGES(2)) dut32 (
        .clk(clk), .rst(rst), .in_valid(iv32), .in_ready(ir32), .a(a32), .b(b32),
        .c_in(ci32), .sub(sb32), .out_valid(ov32), .out_ready(or32), .s(s32),
        .c_out(co32), .ovf(of32), .zero(z32));

    typedef struct packed {
        logic [31:0] s;
        logic        c;
        logic        o;
        logic        z;
    } res_t;

    typedef struct {
        int          w;
        logic [31:0] a;
        logic [31:0] b;
        logic        ci;
        logic        sub;
        logic [31:0] s;
        logic        c;
        logic        o;
        logic        z;
        string       name;
    } vec_t;

    int   vectors = 0;
    int   miscompares = 0;
    int   acc24 = 0;
    int   acc32 = 0;
    res_t q24[$];
    res_t q32[$];

    function automatic res_t model(input int w, input logic [31:0] a, input logic [31:0] b,
                                   input logic ci, input logic sub);
        res_t        r;
        logic [63:0] mask, bb, full;
        mask = (64'd1 << w) - 64'd1;
        bb   = sub ? ((~{32'd0, b}) & mask) : {32'd0, b};
        full = {32'd0, a} + bb + {63'd0, ci};
        r.s  = full[31:0] & mask[31:0];
        r.c  = full[w];
        r.o  = (a[w-1] == bb[w-1]) && (r.s[w-1] != a[w-1]);
        r.z  = (r.s == 32'd0);
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Scoreboards: decide at the falling edge what the next rising edge transfers.
    always @(negedge clk) begin
        res_t e;
        if (!rst) begin
            q24.delete();
        end else begin
            if (iv24 && ir24) begin
                q24.push_back(model(24, 32'(a24), 32'(b24), ci24, sb24));
                acc24++;
            end
            if (ov24 && or24) begin
                if (q24.size() == 0) check("sb24 spurious result", 32'd1, 32'd0);
                else begin
                    e = q24.pop_front();
                    check("sb24 s", 32'(s24), e.s);
                    check("sb24 flags", {29'd0, co24, of24, z24}, {29'd0, e.c, e.o, e.z});
                end
            end
        end
    end

    always @(negedge clk) begin
        res_t e;
        if (!rst) begin
            q32.delete();
        end else begin
            if (iv32 && ir32) begin
                q32.push_back(model(32, 32'(a32), 32'(b32), ci32, sb32));
                acc32++;
            end
            if (ov32 && or32) begin
                if (q32.size() == 0) check("sb32 spurious result", 32'd1, 32'd0);
                else begin
                    e = q32.pop_front();
                    check("sb32 s", 32'(s32), e.s);
                    check("sb32 flags", {29'd0, co32, of32, z32}, {29'd0, e.c, e.o, e.z});
                end
            end
        end
    end

    task automatic run_vec(input vec_t v);
        int lat = (v.w == 24) ? 3 : 2;
        if (v.w == 24) begin
            iv24 = 1'b1; a24 = v.a[23:0]; b24 = v.b[23:0]; ci24 = v.ci; sb24 = v.sub;
        end else begin
            iv32 = 1'b1; a32 = v.a; b32 = v.b; ci32 = v.ci; sb32 = v.sub;
        end
        @(posedge clk); #1;
        iv24 = 1'b0;
        iv32 = 1'b0;
        for (int n = 1; n <= lat; n++) begin
            if (n > 1) begin @(posedge clk); #1; end
            check({v.name, " latency"}, (v.w == 24) ? 32'(ov24) : 32'(ov32), 32'(n == lat));
        end
        if (v.w == 24) begin
            check({v.name, " s"}, 32'(s24), v.s);
            check({v.name, " flags"}, {29'd0, co24, of24, z24}, {29'd0, v.c, v.o, v.z});
        end else begin
            check({v.name, " s"}, 32'(s32), v.s);
            check({v.name, " flags"}, {29'd0, co32, of32, z32}, {29'd0, v.c, v.o, v.z});
        end
    endtask

    vec_t        tbl[11];
    logic [23:0] ta[8] = '{24'h0, 24'hA, 24'h1, 24'h7, 24'hFFFFF0, 24'h800000, 24'h123, 24'h0FF};
    logic [23:0] tb[8] = '{24'h0, 24'h5, 24'hF, 24'h9, 24'h10,     24'h800000, 24'h321, 24'h001};
    logic [23:0] snap_s;
    logic [2:0]  snap_f;
    bit          have_snap;
    int          cyc;

    initial begin
        tbl[0]  = '{24, 32'hFFFFFF, 32'h000001, 1'b0, 1'b0, 32'h000000, 1'b1, 1'b0, 1'b1, "wrap_to_zero"};
        tbl[1]  = '{24, 32'h7FFFFF, 32'h000001, 1'b0, 1'b0, 32'h800000, 1'b0, 1'b1, 1'b0, "pos_ovf"};
        tbl[2]  = '{24, 32'h00000A, 32'h000005, 1'b1, 1'b1, 32'h000005, 1'b1, 1'b0, 1'b0, "sub_10_5"};
        tbl[3]  = '{24, 32'h000005, 32'h00000A, 1'b1, 1'b1, 32'hFFFFFB, 1'b0, 1'b0, 1'b0, "sub_5_10"};
        tbl[4]  = '{24, 32'h800000, 32'h000001, 1'b1, 1'b1, 32'h7FFFFF, 1'b1, 1'b1, 1'b0, "sub_neg_ovf"};
        tbl[5]  = '{24, 32'h000000, 32'h000000, 1'b1, 1'b0, 32'h000001, 1'b0, 1'b0, 1'b0, "cin_only"};
        tbl[6]  = '{24, 32'h123456, 32'h654321, 1'b0, 1'b0, 32'h777777, 1'b0, 1'b0, 1'b0, "no_carry"};
        tbl[7]  = '{24, 32'h000FFF, 32'h000001, 1'b0, 1'b0, 32'h001000, 1'b0, 1'b0, 1'b0, "seg_carry"};
        tbl[8]  = '{24, 32'hFFFFFF, 32'hFFFFFF, 1'b1, 1'b1, 32'h000000, 1'b1, 1'b0, 1'b1, "sub_equal"};
        tbl[9]  = '{32, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0, "w32_all_ones"};
        tbl[10] = '{32, 32'h80000000, 32'h80000000, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b1, 1'b1, "w32_neg_ovf"};

        rst = 1'b0;
        iv24 = 1'b0; a24 = '0; b24 = '0; ci24 = 1'b0; sb24 = 1'b0; or24 = 1'b1;
        iv32 = 1'b0; a32 = '0; b32 = '0; ci32 = 1'b0; sb32 = 1'b0; or32 = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset out_valid24", 32'(ov24), 32'd0);
        check("reset s24", 32'(s24), 32'd0);
        check("reset flags24", {29'd0, co24, of24, z24}, 32'd0);
        check("reset in_ready24", 32'(ir24), 32'd1);
        check("reset out_valid32", 32'(ov32), 32'd0);
        check("reset in_ready32", 32'(ir32), 32'd1);
        rst = 1'b1;

        for (int i = 0; i < 11; i++) run_vec(tbl[i]);

        // Back-to-back: 8 accepts, results on 8 consecutive cycles from cycle 3.
        @(posedge clk); #1;
        for (int e = 1; e <= 11; e++) begin
            if (e <= 8) begin
                iv24 = 1'b1; a24 = ta[e-1]; b24 = tb[e-1]; ci24 = 1'b0; sb24 = 1'b0;
            end else iv24 = 1'b0;
            @(posedge clk); #1;
            check("b2b out_valid", 32'(ov24), 32'(e >= 3 && e <= 10));
        end
        iv24 = 1'b0;

        // Backpressure: consumer stalls while results are in flight.
        or24 = 1'b0;
        have_snap = 1'b0;
        for (int e = 1; e <= 7; e++) begin
            iv24 = 1'b1; a24 = 24'($urandom); b24 = 24'($urandom);
            ci24 = 1'($urandom); sb24 = 1'($urandom);
            @(posedge clk); #1;
            if (e >= 3) begin
                check("bp out_valid", 32'(ov24), 32'd1);
                check("bp in_ready", 32'(ir24), 32'd0);
                if (have_snap) begin
                    check("bp s frozen", 32'(s24), 32'(snap_s));
                    check("bp flags frozen", 32'({co24, of24, z24}), 32'(snap_f));
                end
                snap_s = s24;
                snap_f = {co24, of24, z24};
                have_snap = 1'b1;
            end
        end
        iv24 = 1'b0;
        or24 = 1'b1;
        repeat (6) begin @(posedge clk); #1; end
        check("bp drain queue", 32'(q24.size()), 32'd0);
        check("bp drained out_valid", 32'(ov24), 32'd0);

        // Reset with two results in flight.
        for (int e = 0; e < 2; e++) begin
            iv24 = 1'b1; a24 = 24'h111111 * 24'(e + 1); b24 = 24'h000123; ci24 = 1'b0; sb24 = 1'b0;
            @(posedge clk); #1;
        end
        iv24 = 1'b0;
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        check("rst out_valid", 32'(ov24), 32'd0);
        check("rst s", 32'(s24), 32'd0);
        check("rst flags", {29'd0, co24, of24, z24}, 32'd0);
        check("rst in_ready", 32'(ir24), 32'd1);
        for (int e = 0; e < 5; e++) begin
            @(posedge clk); #1;
            check("rst no stale", 32'(ov24), 32'd0);
        end

        // Random traffic on both instances with random backpressure.
        begin
            int t24 = acc24 + 300;
            int t32 = acc32 + 1000;
            cyc = 0;
            while ((acc24 < t24 || acc32 < t32) && cyc < 20000) begin
                iv24 = ($urandom_range(3) != 0); a24 = 24'($urandom); b24 = 24'($urandom);
                ci24 = 1'($urandom); sb24 = 1'($urandom); or24 = ($urandom_range(3) != 0);
                iv32 = ($urandom_range(3) != 0); a32 = $urandom; b32 = $urandom;
                ci32 = 1'($urandom); sb32 = 1'($urandom); or32 = ($urandom_range(3) != 0);
                if (acc24 >= t24) iv24 = 1'b0;
                if (acc32 >= t32) iv32 = 1'b0;
                @(posedge clk); #1;
                cyc++;
            end
            check("random cycle budget", 32'(cyc < 20000), 32'd1);
        end
        iv24 = 1'b0; iv32 = 1'b0; or24 = 1'b1; or32 = 1'b1;
        repeat (6) begin @(posedge clk); #1; end
        check("final queue24", 32'(q24.size()), 32'd0);
        check("final queue32", 32'(q32.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
